// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract reusing one full-adder cell per clock.
// The result is held stable between operations; sub mode adds ~b with a forced carry-in of 1.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t st, nxt;
   logic [WIDTH-1:0] ra, rb, sh;
   logic [WIDTH-2:0] rs;
   logic [CW-1:0] cnt;
   logic carry, s, nc, last;
   always_comb begin
      s = ra[0] ^ rb[0] ^ carry;
      nc = (ra[0] & rb[0]) | (carry & (ra[0] ^ rb[0]));
      sh = {s, rs};
      last = cnt == CW'(WIDTH - 1);
      busy = st == RUN;
      done = st == DONE;
      nxt = st == IDLE ? (start ? RUN : IDLE) : st == RUN ? (last ? DONE : RUN) : IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st <= IDLE;
      else st <= nxt;
   // carry still holds the carry into the MSB while the last bit is processed
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ra <= '0;
         rb <= '0;
         rs <= '0;
         cnt <= '0;
         carry <= 1'b0;
         sum <= '0;
         cout <= 1'b0;
         ovf <= 1'b0;
      end else if (st == IDLE && start) begin
         ra <= a;
         rb <= sub ? ~b : b;
         carry <= sub | cin;
         cnt <= '0;
      end else if (st == RUN) begin
         ra <= ra >> 1;
         rb <= rb >> 1;
         rs <= sh[WIDTH-1:1];
         carry <= nc;
         cnt <= cnt + CW'(1);
         if (last) begin
            sum <= sh;
            cout <= nc;
            ovf <= carry ^ nc;
         end
      end
endmodule
